// File: rtl/pcm_serial_rx.sv
// pcm_serial_rx: serial PCM byte receiver with a small sample FIFO.
// Shifts in MSB-first bytes framed by fsync on bclk_en strobes, tags each
// byte with the companding law seen at bit 7, and queues the tagged bytes
// for a downstream G711 expander through a valid/ready head interface.
module pcm_serial_rx #(
  parameter int DEPTH = 4,
  parameter int LVL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bclk_en,
  input  logic             fsync,
  input  logic             sdata,
  input  logic             law,
  output logic [7:0]       pcm,
  output logic             pcm_law,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic [LVL_W-1:0] level,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [2:0]       cnt_q;
  logic [7:0]       sr_q;
  logic             tag_q;
  logic             frame_err_q;
  logic             push_q;
  logic [7:0]       push_byte_q;
  logic             push_law_q;

  logic [7:0]       mem_q     [DEPTH];
  logic             mem_law_q [DEPTH];
  logic [LVL_W-1:0] wr_q;
  logic [LVL_W-1:0] rd_q;
  logic [7:0]       last_q;
  logic             last_law_q;
  logic             overrun_q;

  logic [LVL_W-1:0] level_d;
  logic             empty;
  logic             full;
  logic             pop;
  logic             wr_en;
  logic             drop;

  // Frame FSM: bit counter, shift register, law tag, and the one-cycle
  // completed-byte strobe that feeds the FIFO on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      sr_q        <= 8'h00;
      tag_q       <= 1'b0;
      frame_err_q <= 1'b0;
      push_q      <= 1'b0;
    end else begin
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      if (bclk_en) begin
        case (state_q)
          IDLE: begin
            if (fsync) begin
              sr_q    <= {sdata, 7'b0};
              tag_q   <= law;
              cnt_q   <= 3'd1;
              state_q <= SHIFT;
            end
          end
          SHIFT: begin
            if (fsync) begin
              // Early frame sync: drop the partial byte, restart on this bit.
              frame_err_q <= 1'b1;
              sr_q        <= {sdata, 7'b0};
              tag_q       <= law;
              cnt_q       <= 3'd1;
            end else if (cnt_q == 3'd7) begin
              push_q  <= 1'b1;
              sr_q    <= 8'h00;
              cnt_q   <= 3'd0;
              state_q <= IDLE;
            end else begin
              sr_q[3'd7 - cnt_q] <= sdata;
              cnt_q              <= cnt_q + 3'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Completed byte and its law tag, captured alongside the push strobe.
  always_ff @(posedge clk) begin
    if (bclk_en && !fsync && state_q == SHIFT && cnt_q == 3'd7) begin
      push_byte_q <= {sr_q[7:1], sdata};
      push_law_q  <= tag_q;
    end
  end

  // Pointers carry one extra wrap bit so a full FIFO is distinct from empty.
  always_comb begin
    level_d = wr_q - rd_q;
    empty   = (level_d == '0);
    full    = (level_d == LVL_W'(DEPTH));
    pop     = !empty && pcm_ready;
    wr_en   = push_q && (!full || pop);
    drop    = push_q && full && !pop;
  end

  // FIFO storage; a push while full is only accepted when the head pops too.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_q[AW-1:0]]     <= push_byte_q;
      mem_law_q[wr_q[AW-1:0]] <= push_law_q;
    end
  end

  // FIFO pointers, last-popped hold register and sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= '0;
      rd_q       <= '0;
      last_q     <= 8'h00;
      last_law_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + LVL_W'(1);
      if (pop) begin
        rd_q       <= rd_q + LVL_W'(1);
        last_q     <= mem_q[rd_q[AW-1:0]];
        last_law_q <= mem_law_q[rd_q[AW-1:0]];
      end
      // A new overrun outranks a clear arriving on the same edge.
      if (drop) overrun_q <= 1'b1;
      else if (clr_err) overrun_q <= 1'b0;
    end
  end

  // Head-of-FIFO presentation; an empty FIFO keeps showing the last pop.
  always_comb begin
    pcm_valid = !empty;
    pcm       = empty ? last_q : mem_q[rd_q[AW-1:0]];
    pcm_law   = empty ? last_law_q : mem_law_q[rd_q[AW-1:0]];
    level     = level_d;
    overrun   = overrun_q;
    frame_err = frame_err_q;
  end

endmodule
